// File: rtl/demux8_pkg.sv
// -----------------------------------------------------------------------------
// demux8_pkg
// Shared constants and helpers for the addressable 1-to-8 demultiplexing
// output register.
//   N_OUT     : number of registered output bits
//   AW        : address width (log2 of N_OUT)
//   oe_active : decodes the output-enable pin pattern. Outputs drive only for
//               OE1=0, OE2=0, OE3=1. The selecting register uses the same
//               pattern.
// -----------------------------------------------------------------------------
package demux8_pkg;

    localparam int N_OUT = 8;
    localparam int AW    = 3;

    function automatic logic oe_active(input logic oe1,
                                       input logic oe2,
                                       input logic oe3);
        return (!oe1) && (!oe2) && oe3;
    endfunction

endpackage

// File: rtl/demux8_addr_ctr.sv
// -----------------------------------------------------------------------------
// demux8_addr_ctr
// Address latch / auto-increment counter, effective-address mux and DONE pulse.
// Ports:
//   CP   in      clock, rising edge
//   MR   in      asynchronous active-high reset (addr=0, DONE=0)
//   S    in  AW  select input
//   LE   in      address latch enable, active-low (0 = transparent and load)
//   WE   in      write enable
//   AUTO in      auto-increment after each write
//   CLR  in      synchronous clear; suppresses auto-increment
//   ea   out AW  effective address (S when LE=0, else latched address)
//   DONE out     one-cycle pulse after an auto write to the last address
// -----------------------------------------------------------------------------
module demux8_addr_ctr
    import demux8_pkg::*;
(
    input  logic          CP,
    input  logic          MR,
    input  logic [AW-1:0] S,
    input  logic          LE,
    input  logic          WE,
    input  logic          AUTO,
    input  logic          CLR,
    output logic [AW-1:0] ea,
    output logic          DONE
);

    logic [AW-1:0] addr;
    logic          done_r;
    logic          auto_step;

    assign ea        = LE ? addr : S;
    assign auto_step = WE && AUTO && !CLR;
    assign DONE      = done_r;

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            addr   <= '0;
            done_r <= 1'b0;
        end else begin
            // An auto write advances from the effective address, so LE=0
            // with WE=AUTO=1 yields S+1. When CLR blocks the increment and
            // WE=AUTO=1, the address holds even if LE=0.
            if (auto_step) begin
                addr <= ea + AW'(1);
            end else if (!LE && !(WE && AUTO)) begin
                addr <= S;
            end
            done_r <= auto_step && (ea == AW'(N_OUT - 1));
        end
    end

endmodule

// File: rtl/demux8_addressable_reg.sv
// -----------------------------------------------------------------------------
// demux8_addressable_reg
// Addressable 1-to-8 demultiplexing output register with tri-stated output.
// A single data bit is written into the output bit chosen by the effective
// address. Auto mode steps the address so that a byte can be loaded serially.
// Ports:
//   CP            in         clock, rising edge
//   MR            in         asynchronous active-high master reset
//   D             in         data bit to store
//   S             in  AW     address (select) input
//   LE            in         address latch enable, active-low
//   WE            in         write enable
//   AUTO          in         auto-increment address after each write
//   CLR           in         synchronous clear of all output bits (no write)
//   OE1, OE2, OE3 in         output enables; drive only for (0,0,1)
//   Q             out N_OUT  registered outputs, high-Z when not enabled
//   DONE          out        pulse after an auto write to address N_OUT-1
// -----------------------------------------------------------------------------
module demux8_addressable_reg
    import demux8_pkg::*;
(
    input  logic             CP,
    input  logic             MR,
    input  logic             D,
    input  logic [AW-1:0]    S,
    input  logic             LE,
    input  logic             WE,
    input  logic             AUTO,
    input  logic             CLR,
    input  logic             OE1,
    input  logic             OE2,
    input  logic             OE3,
    output logic [N_OUT-1:0] Q,
    output logic             DONE
);

    logic [N_OUT-1:0] q_reg;
    logic [AW-1:0]    ea;

    demux8_addr_ctr u_addr_ctr (
        .CP   (CP),
        .MR   (MR),
        .S    (S),
        .LE   (LE),
        .WE   (WE),
        .AUTO (AUTO),
        .CLR  (CLR),
        .ea   (ea),
        .DONE (DONE)
    );

    // CLR outranks WE. A write touches only the addressed bit.
    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            q_reg <= '0;
        end else if (CLR) begin
            q_reg <= '0;
        end else if (WE) begin
            q_reg[ea] <= D;
        end
    end

    // The enable path is combinational and does not affect stored state.
    assign Q = oe_active(OE1, OE2, OE3) ? q_reg : {N_OUT{1'bz}};

endmodule

// File: doc/demux8_addressable_reg.md
# demux8_addressable_reg

Addressable 1-to-8 demultiplexing output register: the write-side counterpart of the 8-to-1 selecting register. A single data bit is steered into one of eight registered output bits chosen by a latched 3-bit address, with an auto-increment mode for serial loading of a full byte. The block sits on the distribution side of the same bus, shares its select/latch-enable/clock/output-enable pin conventions, and drives a tri-stated 8-bit output.

## Interface
- N_OUT, 8: number of output bits. Fixed at 8 for this release.
- AW, 3: address width, equal to log2(N_OUT).

- CP  in  1  clock. All state changes on the rising edge.
- MR  in  1  master reset: asynchronous, active-high.
- D  in  1  data bit to store.
- S  in  AW  address (select) input.
- LE  in  1  address latch enable, active-low. 0 = address transparent and loaded; 1 = address held.
- WE  in  1  write enable, active-high.
- AUTO  in  1  auto-increment address after each write.
- CLR  in  1  synchronous clear of all output bits, active-high.
- OE1, OE2, OE3  in  1 each  output enable. Outputs are active only when OE1=0, OE2=0 and OE3=1.
- Q  out  N_OUT  registered outputs. High-Z when outputs are not enabled.
- DONE  out  1  one-cycle pulse after an auto-mode write to address N_OUT-1. Never tri-stated.

## Operation
- State: `q_reg[7:0]`, `addr[2:0]`, `done_r`.
- Effective address `ea` = S when LE=0, otherwise `addr`.
- Per rising CP edge, in priority order:
  - CLR=1: `q_reg` <= 0. No write occurs. The address updates per the rules below, but auto-increment does not occur.
  - Otherwise, WE=1: `q_reg[ea]` <= D. All other bits hold.
- Address update on each edge:
  - LE=0 and (WE=0 or AUTO=0): `addr` <= S.
  - WE=1, AUTO=1, CLR=0: `addr` <= `ea` + 1, modulo 8. Address 7 wraps to 0. This applies even when LE=0, giving S + 1.
  - All other cases: `addr` holds.
- DONE: `done_r` <= 1 on any edge where WE=1, AUTO=1, CLR=0 and `ea`=7; otherwise `done_r` <= 0.
- Output: Q = `q_reg` when OE1=0, OE2=0 and OE3=1; otherwise all bits are Z. The OE path is purely combinational.

## Timing
- Reset: when MR=1, immediately `q_reg`=0x00, `addr`=0 and DONE=0. Q reads 0x00 if enabled, Z otherwise. Reset overrides any edge in progress. The first active edge is the first CP rise after MR falls.
- Write latency: Q reflects a write immediately after the writing edge (one-edge latency).
- DONE: rises after the edge that writes address 7 and falls after the next edge.
- A serial byte load (LE=1, AUTO=1, WE=1) from address 0 takes 8 consecutive edges. DONE is asserted in the cycle following the 8th edge.
- Back-to-back bytes need no idle cycle: the address wraps to 0.
- Simultaneous LE=0 and WE=1: the write targets S on that same edge, with no extra cycle.
- MR asserted mid-load abandons the load. The address returns to 0 and the bits already written are cleared.
- OE changes have no effect on state and take effect without a clock.

## Structure
- Package `demux8_pkg`: constants N_OUT and AW, plus an `oe_active` function that encodes the (0,0,1) enable pattern. The pattern is shared with the selecting register.
- Sub-module `demux8_addr_ctr`: address latch and increment, effective-address mux, and DONE generation. The top level holds `q_reg`, the write decode, CLR and the tri-state drivers.

## Test plan
- Reset: MR=1 with OE enabled -> Q=0x00 and DONE=0. After MR falls, LE=0, S=5, D=1, WE=1, one edge -> Q=0x20.
- Latched address: LE=0 with S=3 for one edge, then LE=1 with S=6. Write D=1 -> Q bit 3 set, bit 6 stays 0.
- Auto load: LE=1, AUTO=1, WE=1, start at `addr`=0, D stream 1,0,1,1,0,0,1,0 over 8 edges -> Q=0x4D. DONE is high for exactly one cycle after the 8th edge, and `addr` is 0 afterwards.
- Wrap plus CLR priority: `addr`=7 with auto write D=1 -> bit 7 set, `addr`=0. Then CLR=1 with WE=1 -> Q=0x00, `addr` stays 0, DONE=0.
- Output enable: Q loaded with 0xA5. Sweep all 8 OE combinations -> Q=0xA5 only for (0,0,1), Z for the other 7. `q_reg` is unchanged.
- Reset mid-load: MR pulsed after 4 auto writes -> Q=0x00 and `addr`=0. The next 8 auto writes of all 1s -> Q=0xFF, and DONE pulses once.
